// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator front-end.
//   - CALC_WIDTH / CALC_OP_WIDTH: datapath defaults, shared with Calculator.
//   - S_A .. S_SHOW: operand-sequencer state encodings (3-bit).
package calc_pkg;
  localparam int CALC_WIDTH    = 4;
  localparam int CALC_OP_WIDTH = 3;

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: rising-edge detector for an already-synchronized level.
// Ports:
//   clk, rst - clock, async active-high reset
//   in       - level input
//   rise     - high for the cycle where in is 1 and was 0 at the previous edge
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic r_in_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_in_q <= 1'b0;
    else     r_in_q <= in;
  end

  assign rise = in & ~r_in_q;
endmodule

// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer: collects A, B and opcode from a shared switch bus,
// one per enter press, holds them on the Calculator inputs and registers the
// Calculator result for display.
// Ports:
//   clk, rst         - clock, async active-high reset
//   sw[WIDTH]        - operand / opcode entry bus
//   enter            - enter button level (edge-detected here)
//   clear            - synchronous clear, beats a simultaneous advance
//   result[WIDTH]    - from Calculator.out, sampled only in S_EXEC
//   a, b, op         - held operands/opcode to Calculator
//   out, done        - displayed result and its valid flag
//   state[3]         - FSM state for LEDs
// Build option: CALC_CHAIN_EN - an advance in S_SHOW loads a from out and
// goes to S_B so the next operation chains on the previous result.
module calc_operand_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH    = CALC_WIDTH,
  parameter int OP_WIDTH = CALC_OP_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    sw,
  input  logic                enter,
  input  logic                clear,
  input  logic [WIDTH-1:0]    result,
  output logic [WIDTH-1:0]    a,
  output logic [WIDTH-1:0]    b,
  output logic [OP_WIDTH-1:0] op,
  output logic [WIDTH-1:0]    out,
  output logic                done,
  output logic [2:0]          state
);
  logic                w_adv;
  logic [2:0]          r_state;
  logic [WIDTH-1:0]    r_a, r_b, r_out;
  logic [OP_WIDTH-1:0] r_op;
  logic                r_done;

  edge_detect u_enter_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (enter),
    .rise (w_adv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else if (clear) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_A: if (w_adv) begin
          r_a     <= sw;
          r_state <= S_B;
        end
        S_B: if (w_adv) begin
          r_b     <= sw;
          r_state <= S_OP;
        end
        S_OP: if (w_adv) begin
          r_op    <= sw[OP_WIDTH-1:0];
          r_state <= S_EXEC;
        end
        // Single cycle; operands have been stable since the opcode edge.
        S_EXEC: begin
          r_out   <= result;
          r_done  <= 1'b1;
          r_state <= S_SHOW;
        end
        S_SHOW: if (w_adv) begin
          r_done  <= 1'b0;
`ifdef CALC_CHAIN_EN
          r_a     <= r_out;
          r_state <= S_B;
`else
          r_state <= S_A;
`endif
        end
        // Unused codes recover to S_A.
        default: r_state <= S_A;
      endcase
    end
  end

  assign a     = r_a;
  assign b     = r_b;
  assign op    = r_op;
  assign out   = r_out;
  assign done  = r_done;
  assign state = r_state;
endmodule

// File: tb/tb_calc_operand_sequencer.sv
module tb_calc_operand_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       enter, clear;
  logic [3:0] result;
  logic [3:0] a, b, out;
  logic [2:0] op, state;
  logic       done;

  int total = 0;
  int bad   = 0;

  calc_operand_sequencer dut (
    .clk(clk), .rst(rst), .sw(sw), .enter(enter), .clear(clear),
    .result(result), .a(a), .b(b), .op(op), .out(out), .done(done),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic       en;
    logic       clr;
    logic [3:0] res;
    logic [2:0] st;
    logic [3:0] ea, eb;
    logic [2:0] eop;
    logic [3:0] eout;
    logic       edone;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] s, logic e, logic c, logic [3:0] r,
                              logic [2:0] st, logic [3:0] ea, logic [3:0] eb,
                              logic [2:0] eop, logic [3:0] eo, logic ed);
    vec_t v;
    v.sw = s; v.en = e; v.clr = c; v.res = r; v.st = st;
    v.ea = ea; v.eb = eb; v.eop = eop; v.eout = eo; v.edone = ed;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [2:0] st, logic [3:0] ea, logic [3:0] eb,
                         logic [2:0] eop, logic [3:0] eo, logic ed);
    chk({tag, ".state"}, int'(state), int'(st));
    chk({tag, ".a"},     int'(a),     int'(ea));
    chk({tag, ".b"},     int'(b),     int'(eb));
    chk({tag, ".op"},    int'(op),    int'(eop));
    chk({tag, ".out"},   int'(out),   int'(eo));
    chk({tag, ".done"},  int'(done),  int'(ed));
  endtask

  task automatic step(logic [3:0] s, logic e, logic c, logic [3:0] r);
    @(negedge clk);
    sw = s; enter = e; clear = c; result = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sw = '0; enter = 1'b0; clear = 1'b0; result = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw = '0; enter = 1'b0; clear = 1'b0; result = '0;

    // state, a, b, op, out, done expected after each edge
    tbl.push_back(mk(4'd3, 1, 0, 4'h0, 3'd1, 4'd3, 4'd0, 3'd0, 4'h0, 0));
    tbl.push_back(mk(4'd6, 1, 0, 4'h0, 3'd1, 4'd3, 4'd0, 3'd0, 4'h0, 0)); // held
    tbl.push_back(mk(4'd6, 0, 0, 4'h0, 3'd1, 4'd3, 4'd0, 3'd0, 4'h0, 0));
    tbl.push_back(mk(4'd6, 1, 0, 4'h0, 3'd2, 4'd3, 4'd6, 3'd0, 4'h0, 0));
    tbl.push_back(mk(4'd9, 0, 0, 4'hA, 3'd2, 4'd3, 4'd6, 3'd0, 4'h0, 0));
    tbl.push_back(mk(4'd9, 1, 0, 4'hA, 3'd3, 4'd3, 4'd6, 3'd1, 4'h0, 0)); // sw[3] dropped
    tbl.push_back(mk(4'd9, 1, 0, 4'hA, 3'd4, 4'd3, 4'd6, 3'd1, 4'hA, 1)); // EXEC
    tbl.push_back(mk(4'd9, 0, 0, 4'h3, 3'd4, 4'd3, 4'd6, 3'd1, 4'hA, 1)); // result ignored
    tbl.push_back(mk(4'd0, 0, 1, 4'h0, 3'd0, 4'd0, 4'd0, 3'd0, 4'h0, 0)); // clear in SHOW
    // enter held high 10 cycles in S_A: one advance only
    tbl.push_back(mk(4'd7, 1, 0, 4'h0, 3'd1, 4'd7, 4'd0, 3'd0, 4'h0, 0));
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(4'd8, 1, 0, 4'h0, 3'd1, 4'd7, 4'd0, 3'd0, 4'h0, 0));
    tbl.push_back(mk(4'd2, 0, 0, 4'h0, 3'd1, 4'd7, 4'd0, 3'd0, 4'h0, 0));
    tbl.push_back(mk(4'd2, 1, 0, 4'h0, 3'd2, 4'd7, 4'd2, 3'd0, 4'h0, 0));
    tbl.push_back(mk(4'd4, 0, 0, 4'h0, 3'd2, 4'd7, 4'd2, 3'd0, 4'h0, 0));
    // clear beats an enter edge in S_OP
    tbl.push_back(mk(4'd4, 1, 1, 4'h0, 3'd0, 4'd0, 4'd0, 3'd0, 4'h0, 0));

    do_reset();
    #1;
    chk_all("reset", 3'd0, 4'd0, 4'd0, 3'd0, 4'h0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].sw, tbl[i].en, tbl[i].clr, tbl[i].res);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].ea, tbl[i].eb,
              tbl[i].eop, tbl[i].eout, tbl[i].edone);
    end

    // Async reset between edges while in S_B
    do_reset();
    step(4'd5, 1, 0, 4'h0);
    step(4'd5, 0, 0, 4'h0);
    chk_all("preasync", 3'd1, 4'd5, 4'd0, 3'd0, 4'h0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all("async", 3'd0, 4'd0, 4'd0, 3'd0, 4'h0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Chaining: reach S_SHOW with out=5, then enter edge with sw=2
    step(4'd1, 1, 0, 4'h5);
    step(4'd1, 0, 0, 4'h5);
    step(4'd1, 1, 0, 4'h5);
    step(4'd0, 0, 0, 4'h5);
    step(4'd0, 1, 0, 4'h5);
    step(4'd0, 0, 0, 4'h5);
    chk_all("show", 3'd4, 4'd1, 4'd1, 3'd0, 4'h5, 1);
    step(4'd2, 1, 0, 4'h0);
`ifdef CALC_CHAIN_EN
    chk_all("chain", 3'd1, 4'd5, 4'd1, 3'd0, 4'h5, 0);
`else
    chk_all("chain", 3'd0, 4'd1, 4'd1, 3'd0, 4'h5, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/calc_operand_sequencer.md
# calc_operand_sequencer

Front-end sequencer that sits directly upstream of the 4-bit `Calculator` block. It collects operand A, operand B and the opcode one at a time from a shared 4-bit switch bus, advancing on each press of an enter button. It holds those values stable on the `Calculator` inputs, then registers the calculator's combinational result for display. It turns the purely combinational datapath into a usable, clocked, button-driven unit.

## Interface
Parameters:
- `WIDTH`, 4 — operand/result width; must match the `Calculator` datapath.
- `OP_WIDTH`, 3 — opcode width.

Ports (clock and reset first):
- `clk`  input  1 — single system clock; all state updates on its rising edge.
- `rst`  input  1 — asynchronous, active-high reset.
- `sw`  input  WIDTH — switch bus; carries the operand or opcode value being entered.
- `enter`  input  1 — enter button, level, already synchronized; the block edge-detects it internally.
- `clear`  input  1 — synchronous clear; abandons the current entry.
- `result`  input  WIDTH — driven by `Calculator.out`.
- `a`  output  WIDTH — registered operand A, drives `Calculator.a`.
- `b`  output  WIDTH — registered operand B, drives `Calculator.b`.
- `op`  output  OP_WIDTH — registered opcode, drives `Calculator.op`.
- `out`  output  WIDTH — registered result for display.
- `done`  output  1 — high while a valid result is held in `out`.
- `state`  output  3 — current FSM state, intended for LEDs.

## Operation
- Enter edge detection:
  - `enter_q` is a one-cycle delayed copy of `enter`.
  - An advance occurs when `enter & ~enter_q`.
  - Holding `enter` high produces exactly one advance.
- FSM states and encodings: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
  - S_A: on advance, `a <= sw`; go to S_B.
  - S_B: on advance, `b <= sw`; go to S_OP.
  - S_OP: on advance, `op <= sw[OP_WIDTH-1:0]` (`sw[3]` is ignored); go to S_EXEC.
  - S_EXEC: unconditional single cycle. `out <= result` and `done <= 1`; go to S_SHOW. Advances during S_EXEC are ignored.
  - S_SHOW: `out`, `a`, `b` and `op` hold. On advance, `done <= 0` and go to S_A (see Configuration for the alternative).
- `a`, `b` and `op` change only on their own entry edge, so `Calculator` inputs are stable throughout S_EXEC.
- `clear`:
  - Effective in any state.
  - Forces S_A and zeroes `a`, `b`, `op`, `out` and `done`.
  - Takes priority over a simultaneous advance.
- Codes 5–7 are unused. If one is reached it returns to S_A on the next clock.

## Timing
- Reset values:
  - `a`, `b`, `op`, `out` = 0.
  - `done` = 0.
  - `state` = S_A.
  - `enter_q` = 0.
- Asserting `rst` mid-operation forces all of the above immediately, without waiting for a clock edge.
- Entry capture: if `enter` is sampled high at edge k (with `enter_q` low), the register and state update at edge k.
- Result latency: the opcode advance is at edge k; S_EXEC occupies cycle k→k+1; `out` and `done` are valid after edge k+1.
- `result` is sampled only at the S_EXEC edge. Changes on `result` at any other time have no effect.
- A new advance needs `enter` low for at least one sampled edge first.

## Configuration
- Macro: `CALC_CHAIN_EN`.
  - Defined: an advance in S_SHOW does `a <= out` and `done <= 0`, then goes to S_B. The next computation chains on the previous result and `sw` is ignored on that edge. `clear` still returns to S_A.
  - Undefined: an advance in S_SHOW goes to S_A and `a` holds until the next A entry.

## Structure
- Package `calc_pkg` holds:
  - the state encodings (S_A … S_SHOW) as localparams;
  - the `WIDTH`/`OP_WIDTH` defaults, shared with `Calculator`.
- Sub-module `edge_detect` (ports: `clk`, `rst`, `in`, `rise`) owns `enter_q`. It is instantiated once.
- The top level of the sequencer is the FSM plus the `a`/`b`/`op`/`out` registers. `Calculator` is instantiated alongside it by the parent, not inside this block.

## Test plan
- Reset: assert `rst`, then release → `a`=`b`=`op`=`out`=0, `done`=0, `state`=0.
- Full entry:
  - Stimulus: `sw`=3 + enter, then `sw`=6 + enter, then `sw`=4'b1001 + enter; bench drives `result`=4'hA.
  - Required: `a`=3, `b`=6, `op`=3'b001; `done`=1 and `out`=4'hA exactly one cycle after the opcode edge; `state`=4.
- Held button: `enter` held high for 10 cycles in S_A → exactly one advance (`state`=1).
- Clear priority: in S_OP, assert `clear` and an enter edge in the same cycle → `state`=0, `a`=`b`=`op`=`out`=0.
- Async reset mid-entry: assert `rst` between clock edges while in S_B → outputs reach reset values before the next edge.
- Chaining, starting from S_SHOW with `out`=5, then an enter edge with `sw`=2:
  - With `CALC_CHAIN_EN` defined → `a`=5, `state`=1.
  - Without it → `state`=0, `a` unchanged.
